// File: rtl/display_pkg.sv
// Shared types for the seven-segment display scan path.
package display_pkg;

    localparam int unsigned DIGITS = 4;

    typedef logic [3:0]              digit_t;
    typedef logic [1:0]              sel_t;
    typedef digit_t [DIGITS-1:0]     frame_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count of each slot.
module tick_divider #(
    parameter int unsigned DIV = 100_000,
    localparam int unsigned CW = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    assign tick = (cnt == CW'(DIV - 1));

    // Prescaler counter, wraps to zero on the tick edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with a tear-free shadow buffer.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned DIV   = 100_000,
    parameter int unsigned BLANK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output sel_t        sel,
    output digit_t      digit,
    output logic        blank,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic          tick;
    logic          boundary;
    logic          accept;
    logic          suppress;
    frame_t        active;
    frame_t        pending;
    logic          pending_full;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .tick  (tick)
    );

    assign boundary   = tick && (sel == sel_t'(DIGITS - 1));
    assign load_ready = !pending_full;
    assign accept     = load_valid && load_ready;
    assign digit      = active[sel];
    assign blank      = (cnt < CW'(BLANK)) || suppress;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank slot sel when it and every more-significant nibble are zero; slot 0 always shows.
    always_comb begin
        suppress = (sel != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(sel) && active[k] != '0) begin
                suppress = 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Digit index advances once per slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel <= '0;
        end else if (tick) begin
            sel <= sel + sel_t'(1);
        end
    end

    // Shadow buffer: accept into pending, promote to active only at a frame boundary.
    // Accept and promote are exclusive since accept needs pending_full low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (accept) begin
                pending <= load_data;
            end
            if (boundary && pending_full) begin
                active <= pending;
            end
            pending_full <= accept || (pending_full && !boundary);
        end
    end

    // Registered frame pulse, aligned with sel==0, cnt==0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIV=4, BLANK=1.
module tb_display_scan_controller;
    import display_pkg::*;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    sel_t        sel;
    digit_t      digit;
    logic        blank;
    logic        frame_done;

    int tests;
    int fails;
    int k;  // rising edges since reset release

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    display_scan_controller #(
        .DIV   (4),
        .BLANK (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sel        (sel),
        .digit      (digit),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          k;
        logic [3:0]  digit;
        logic        ready;
        logic        lv;
        logic [15:0] ld;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at k=%0d: got %h, want %h", name, k, act, exp);
        end
    endtask

    // Scan position checks derived from the edge count alone.
    task automatic check_timing();
        int es;
        int ec;
        es = (k / 4) % 4;
        ec = k % 4;
        chk("sel", 16'(sel), 16'(es));
        chk("frame_done", 16'(frame_done), 16'((k > 0) && (k % 16 == 0)));
        if (!LZB || es == 0 || ec == 0) begin
            chk("blank", 16'(blank), 16'(ec == 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check_timing();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        k          = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;

        //           k   digit  rdy   lv    data after check
        vecs[0]  = '{0,  4'h0, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{2,  4'h0, 1'b1, 1'b1, 16'h1234};
        vecs[2]  = '{3,  4'h0, 1'b0, 1'b1, 16'hABCD};
        vecs[3]  = '{8,  4'h0, 1'b0, 1'b1, 16'hABCD};
        vecs[4]  = '{15, 4'h0, 1'b0, 1'b1, 16'hABCD};
        vecs[5]  = '{16, 4'h4, 1'b1, 1'b1, 16'hABCD};
        vecs[6]  = '{17, 4'h4, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{20, 4'h3, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{24, 4'h2, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{28, 4'h1, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{31, 4'h1, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{32, 4'hD, 1'b1, 1'b0, 16'h0000};
        vecs[12] = '{33, 4'hD, 1'b1, 1'b0, 16'h0000};
        vecs[13] = '{36, 4'hC, 1'b1, 1'b0, 16'h0000};
        vecs[14] = '{47, 4'hA, 1'b1, 1'b1, 16'h5678};
        vecs[15] = '{48, 4'hD, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{52, 4'hC, 1'b0, 1'b0, 16'h0000};
        vecs[17] = '{63, 4'hA, 1'b0, 1'b0, 16'h0000};
        vecs[18] = '{64, 4'h8, 1'b1, 1'b0, 16'h0000};
        vecs[19] = '{68, 4'h7, 1'b1, 1'b0, 16'h0000};
        vecs[20] = '{73, 4'h6, 1'b1, 1'b1, 16'h9999};
        vecs[21] = '{74, 4'h6, 1'b0, 1'b0, 16'h0000};

        // Reset state while reset is held.
        #12;
        chk("rst_digit", 16'(digit), 16'h0);
        chk("rst_ready", 16'(load_ready), 16'h1);
        chk("rst_blank", 16'(blank), 16'h1);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        check_timing();

        for (int i = 0; i < 22; i++) begin
            run_to(vecs[i].k);
            chk("digit", 16'(digit), 16'(vecs[i].digit));
            chk("load_ready", 16'(load_ready), 16'(vecs[i].ready));
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
        end

        // Mid-slot reset (sel=2, cnt=2, pending full): must clear without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("async_sel", 16'(sel), 16'h0);
        chk("async_digit", 16'(digit), 16'h0);
        chk("async_ready", 16'(load_ready), 16'h1);
        chk("async_blank", 16'(blank), 16'h1);
        chk("async_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;

        // Restart from slot 0 with cleared active frame, then load 0045.
        load_valid = 1'b1;
        load_data  = 16'h0045;
        step();
        load_valid = 1'b0;
        chk("lz_ready", 16'(load_ready), 16'h0);
        run_to(4);
        chk("restart_digit", 16'(digit), 16'h0);
        run_to(16);
        chk("lz_d0", 16'(digit), 16'h5);
        chk("lz_ready2", 16'(load_ready), 16'h1);
        run_to(17);
        chk("lz_b0", 16'(blank), 16'h0);
        run_to(21);
        chk("lz_d1", 16'(digit), 16'h4);
        chk("lz_b1", 16'(blank), 16'h0);
        run_to(25);
        chk("lz_d2", 16'(digit), 16'h0);
        chk("lz_b2", 16'(blank), 16'(LZB));
        run_to(29);
        chk("lz_b3", 16'(blank), 16'(LZB));
        load_valid = 1'b1;
        load_data  = 16'h0000;
        step();
        load_valid = 1'b0;
        run_to(33);
        chk("z_d0", 16'(digit), 16'h0);
        chk("z_b0", 16'(blank), 16'h0);
        run_to(37);
        chk("z_b1", 16'(blank), 16'(LZB));
        run_to(41);
        chk("z_b2", 16'(blank), 16'(LZB));
        run_to(45);
        chk("z_b3", 16'(blank), 16'(LZB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
